snitch_icache_refill_beats: RTL and testbench
=============================================

Name: snitch_icache_refill_beats

Overview:
- Refill engine directly downstream of the icache miss handler.
- Accepts one line-refill request (address, pending-table ID) from the handler and splits it into BEATS sequential narrow memory reads. Assembles the returned beats into a full cache line.
- Returns the line, a sticky error flag and the original ID on the handler's refill-response port.
- One refill in flight at a time; memory read requests and responses overlap within a refill.

Parameters:
- FETCH_AW, 48, byte address width of refill requests and memory requests.
- LINE_WIDTH, 256, cache line width in bits; must be a multiple of MEM_DW.
- MEM_DW, 64, memory data width in bits; power of two, at least 8.
- PENDING_IW, 2, width of the refill ID (pending-table index).
- Derived: BEATS = LINE_WIDTH/MEM_DW (at least 2); LINE_ALIGN = log2(LINE_WIDTH/8); BEAT_BYTES = MEM_DW/8; CNT_W = clog2(BEATS+1).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- in_req_addr_i  in  FETCH_AW  refill byte address; low LINE_ALIGN bits are ignored.
- in_req_id_i  in  PENDING_IW  refill ID.
- in_req_valid_i  in  1  refill request valid.
- in_req_ready_o  out  1  refill request accepted.
- in_rsp_data_o  out  LINE_WIDTH  assembled line.
- in_rsp_error_o  out  1  OR of all beat errors.
- in_rsp_id_o  out  PENDING_IW  ID of the completed refill.
- in_rsp_valid_o  out  1  line response valid.
- in_rsp_ready_i  in  1  line response accepted.
- mem_req_addr_o  out  FETCH_AW  beat byte address.
- mem_req_valid_o  out  1  beat read request valid.
- mem_req_ready_i  in  1  beat read request accepted.
- mem_rsp_data_i  in  MEM_DW  beat read data.
- mem_rsp_error_i  in  1  beat read error.
- mem_rsp_valid_i  in  1  beat response valid; responses return in request order.
- mem_rsp_ready_o  out  1  beat response accepted.

Behaviour:
- Interface decision: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset:
  - State goes to IDLE; counters, error flag, data buffer, address and ID registers are cleared.
  - While rst_i is high and in the first cycle after it falls: in_req_ready_o=0, in_rsp_valid_o=0, mem_req_valid_o=0, mem_rsp_ready_o=0.
  - From the second cycle after reset: IDLE drives in_req_ready_o=1.
  - Reset mid-refill aborts immediately; no response is produced. Memory responses still outstanding at reset are not tracked, and the environment must not deliver them.
- States: IDLE, FETCH, RESP.
- IDLE:
  - in_req_ready_o=1.
  - On in_req_valid_i: latch base = in_req_addr_i with the low LINE_ALIGN bits zeroed, and latch id.
  - Clear req_cnt, rsp_cnt and err; go to FETCH.
- FETCH:
  - mem_req_valid_o = (req_cnt < BEATS); mem_req_addr_o = base + req_cnt*BEAT_BYTES.
  - req_cnt increments on each mem_req handshake.
  - mem_rsp_ready_o = (rsp_cnt < req_cnt), counting a request handshake in the same cycle as outstanding only from the next cycle.
  - On each mem_rsp handshake: write the data to buffer bits [rsp_cnt*MEM_DW +: MEM_DW]; err |= mem_rsp_error_i; rsp_cnt increments.
  - A response whose rsp_cnt becomes BEATS moves the state to RESP in the next cycle.
  - mem_rsp_valid_i with no request outstanding is ignored (ready=0); the bench flags it as a protocol error.
  - A request handshake and a response handshake in the same cycle are both processed.
- RESP:
  - in_rsp_valid_o=1, in_rsp_data_o=buffer, in_rsp_error_o=err, in_rsp_id_o=id.
  - Outputs stay stable until in_rsp_ready_i; on the handshake go to IDLE.
  - in_req_ready_o=0 in RESP, so a new request is accepted at the earliest one cycle after the response handshake.
- Outside the states where they are driven:
  - mem_req_valid_o=0 and mem_rsp_ready_o=0 outside FETCH.
  - in_rsp_valid_o=0 outside RESP; in_rsp data, error and ID outputs hold their last values.
- Errors: err is sticky per refill. All beats are always fetched even after an error, and errored beat data is stored as received.
- Address arithmetic:
  - Beat addresses are computed modulo 2^FETCH_AW.
  - Beats never cross a line because base is line-aligned.
- Latency, with ready always high and memory responding one cycle after each request:
  - Accept at cycle 0; requests at cycles 1..BEATS; responses at cycles 2..BEATS+1.
  - in_rsp_valid_o at cycle BEATS+2.
- Valid outputs never depend combinationally on the corresponding ready input.

Test Plan:
- Basic refill, BEATS=4: accept addr 0x1000_0013, id 2 -> mem addrs 0x1000_0000, 0x08, 0x10, 0x18; beats 0xA0..A3 land at bits [63:0]..[255:192]; in_rsp_id_o=2, error=0, valid at cycle 6.
- Error beat: third beat returns error=1 -> all 4 beats still requested; in_rsp_error_o=1; the following refill reports error=0.
- Backpressure: mem_req_ready_i toggles 1/0, response latency 3 cycles, in_rsp_ready_i held low 5 cycles -> no beat dropped or reordered; outputs stable until the handshake; in_req_ready_o stays 0 until the cycle after the handshake.
- Back-to-back: two requests (ids 0 and 1) presented continuously -> the second is accepted exactly one cycle after the first response handshake, with a correct second line.
- Reset mid-refill: assert rst_i after 2 beats are returned -> next cycle all valids 0 and no response; a new refill after reset completes with correct data.
- Wrap-around: addr 0xFFFF_FFFF_FFE0 (FETCH_AW=48) -> beat addresses ...FFE0, ...FFE8, ...FFF0, ...FFF8 with no overflow into the next line.

Source files
------------

// File: rtl/snitch_icache_refill_beats.sv
// Refill engine sitting behind the icache miss handler.
//
// Takes one line-refill request (address + pending-table ID), issues BEATS
// sequential narrow memory reads, and assembles the returned beats into a full
// cache line. The line, a sticky error flag and the original ID are returned on
// the refill-response port. One refill is in flight at a time; beat requests
// and beat responses overlap within a refill.
//
// Ports:
//   clk_i, rst_i          clock (rising edge), synchronous active-high reset
//   in_req_*              refill request from the miss handler (addr, id)
//   in_rsp_*              assembled line, sticky error, id back to the handler
//   mem_req_*             beat read requests (byte address)
//   mem_rsp_*             beat read responses (in request order)
module snitch_icache_refill_beats #(
    parameter int unsigned FETCH_AW   = 48,
    parameter int unsigned LINE_WIDTH = 256,
    parameter int unsigned MEM_DW     = 64,
    parameter int unsigned PENDING_IW = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [FETCH_AW-1:0]   in_req_addr_i,
    input  logic [PENDING_IW-1:0] in_req_id_i,
    input  logic                  in_req_valid_i,
    output logic                  in_req_ready_o,
    output logic [LINE_WIDTH-1:0] in_rsp_data_o,
    output logic                  in_rsp_error_o,
    output logic [PENDING_IW-1:0] in_rsp_id_o,
    output logic                  in_rsp_valid_o,
    input  logic                  in_rsp_ready_i,
    output logic [FETCH_AW-1:0]   mem_req_addr_o,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    input  logic [MEM_DW-1:0]     mem_rsp_data_i,
    input  logic                  mem_rsp_error_i,
    input  logic                  mem_rsp_valid_i,
    output logic                  mem_rsp_ready_o
);

    localparam int unsigned BEATS      = LINE_WIDTH / MEM_DW;
    localparam int unsigned LINE_ALIGN = $clog2(LINE_WIDTH / 8);
    localparam int unsigned BEAT_BYTES = MEM_DW / 8;
    localparam int unsigned BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam int unsigned CNT_W      = $clog2(BEATS + 1);

    typedef enum logic [1:0] {StIdle, StFetch, StResp} state_e;

    state_e                state_q, state_d;
    logic                  init_q;
    logic [FETCH_AW-1:0]   base_q, base_d;
    logic [PENDING_IW-1:0] id_q, id_d;
    logic [CNT_W-1:0]      req_cnt_q, req_cnt_d;
    logic [CNT_W-1:0]      rsp_cnt_q, rsp_cnt_d;
    logic                  err_q, err_d;
    logic [LINE_WIDTH-1:0] buf_q, buf_d;
    // Separate response registers so the handler-facing outputs hold their
    // last values while the next refill is being assembled.
    logic [LINE_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [PENDING_IW-1:0] rsp_id_q, rsp_id_d;

    logic active;
    logic unused_addr_bits;

    // Low address bits select a byte within the line and are dropped.
    assign unused_addr_bits = ^in_req_addr_i[LINE_ALIGN-1:0];

    // All handshake outputs are forced low while reset is asserted.
    assign active = ~rst_i;

    assign mem_req_addr_o = base_q + (FETCH_AW'(req_cnt_q) << BEAT_SHIFT);
    assign in_rsp_data_o  = rsp_data_q;
    assign in_rsp_error_o = rsp_err_q;
    assign in_rsp_id_o    = rsp_id_q;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        id_d       = id_q;
        req_cnt_d  = req_cnt_q;
        rsp_cnt_d  = rsp_cnt_q;
        err_d      = err_q;
        buf_d      = buf_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        rsp_id_d   = rsp_id_q;

        in_req_ready_o  = 1'b0;
        in_rsp_valid_o  = 1'b0;
        mem_req_valid_o = 1'b0;
        mem_rsp_ready_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                // init_q keeps ready low in the first cycle after reset.
                in_req_ready_o = active & init_q;
                if (in_req_ready_o && in_req_valid_i) begin
                    base_d    = {in_req_addr_i[FETCH_AW-1:LINE_ALIGN], {LINE_ALIGN{1'b0}}};
                    id_d      = in_req_id_i;
                    req_cnt_d = '0;
                    rsp_cnt_d = '0;
                    err_d     = 1'b0;
                    state_d   = StFetch;
                end
            end
            StFetch: begin
                mem_req_valid_o = active && (req_cnt_q < CNT_W'(BEATS));
                // Registered counts: a request accepted this cycle becomes
                // eligible for its response only from the next cycle.
                mem_rsp_ready_o = active && (rsp_cnt_q < req_cnt_q);
                if (mem_req_valid_o && mem_req_ready_i) begin
                    req_cnt_d = req_cnt_q + 1'b1;
                end
                if (mem_rsp_ready_o && mem_rsp_valid_i) begin
                    for (int unsigned b = 0; b < BEATS; b++) begin
                        if (rsp_cnt_q == CNT_W'(b)) begin
                            buf_d[b*MEM_DW +: MEM_DW] = mem_rsp_data_i;
                        end
                    end
                    err_d     = err_q | mem_rsp_error_i;
                    rsp_cnt_d = rsp_cnt_q + 1'b1;
                    if (rsp_cnt_q == CNT_W'(BEATS - 1)) begin
                        rsp_data_d = buf_d;
                        rsp_err_d  = err_d;
                        rsp_id_d   = id_q;
                        state_d    = StResp;
                    end
                end
            end
            StResp: begin
                in_rsp_valid_o = active;
                if (in_rsp_valid_o && in_rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            init_q     <= 1'b0;
            base_q     <= '0;
            id_q       <= '0;
            req_cnt_q  <= '0;
            rsp_cnt_q  <= '0;
            err_q      <= 1'b0;
            buf_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            rsp_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            init_q     <= 1'b1;
            base_q     <= base_d;
            id_q       <= id_d;
            req_cnt_q  <= req_cnt_d;
            rsp_cnt_q  <= rsp_cnt_d;
            err_q      <= err_d;
            buf_q      <= buf_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

endmodule

// File: tb/tb_snitch_icache_refill_beats.sv
// Directed bench for snitch_icache_refill_beats (BEATS = 4, MEM_DW = 64).
// Inputs are driven on the falling edge, outputs sampled 1 time unit later.
module tb_snitch_icache_refill_beats;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [47:0]   in_req_addr_i = '0;
    logic [1:0]    in_req_id_i = '0;
    logic          in_req_valid_i = 1'b0;
    logic          in_req_ready_o;
    logic [255:0]  in_rsp_data_o;
    logic          in_rsp_error_o;
    logic [1:0]    in_rsp_id_o;
    logic          in_rsp_valid_o;
    logic          in_rsp_ready_i = 1'b0;
    logic [47:0]   mem_req_addr_o;
    logic          mem_req_valid_o;
    logic          mem_req_ready_i = 1'b0;
    logic [63:0]   mem_rsp_data_i = '0;
    logic          mem_rsp_error_i = 1'b0;
    logic          mem_rsp_valid_i = 1'b0;
    logic          mem_rsp_ready_o;

    snitch_icache_refill_beats #(
        .FETCH_AW  (48),
        .LINE_WIDTH(256),
        .MEM_DW    (64),
        .PENDING_IW(2)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .in_req_addr_i  (in_req_addr_i),
        .in_req_id_i    (in_req_id_i),
        .in_req_valid_i (in_req_valid_i),
        .in_req_ready_o (in_req_ready_o),
        .in_rsp_data_o  (in_rsp_data_o),
        .in_rsp_error_o (in_rsp_error_o),
        .in_rsp_id_o    (in_rsp_id_o),
        .in_rsp_valid_o (in_rsp_valid_o),
        .in_rsp_ready_i (in_rsp_ready_i),
        .mem_req_addr_o (mem_req_addr_o),
        .mem_req_valid_o(mem_req_valid_o),
        .mem_req_ready_i(mem_req_ready_i),
        .mem_rsp_data_i (mem_rsp_data_i),
        .mem_rsp_error_i(mem_rsp_error_i),
        .mem_rsp_valid_i(mem_rsp_valid_i),
        .mem_rsp_ready_o(mem_rsp_ready_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    // Observations of the most recent refill.
    logic [47:0]  r_addr [4];
    int           r_nreq, r_valid_cyc, r_vcnt, r_accept_wait;
    logic [255:0] r_data;
    logic         r_err;
    logic [1:0]   r_id;
    bit           r_stable, r_busy_ready, r_timeout;

    // Drives one refill: request, a memory with fixed latency 'lat' (data of
    // beat i is dbase+i, beat err_beat flagged), optional toggling
    // mem_req_ready, and in_rsp_ready held low for 'hold' valid cycles.
    // chain keeps a follow-up request asserted once this one is accepted.
    // abort_after > 0 returns as soon as that many beats were returned.
    task automatic run_refill(input logic [47:0] addr, input logic [1:0] id, input int lat,
                              input bit toggle, input int hold, input int err_beat,
                              input logic [63:0] dbase, input int abort_after, input bit chain,
                              input logic [47:0] naddr, input logic [1:0] nid);
        logic [63:0] q_data[$];
        logic        q_err[$];
        int          q_due[$];
        int          cyc, nreq, nrsp;
        bit          done, seen;
        r_nreq = 0; r_valid_cyc = -1; r_vcnt = 0; r_accept_wait = 0;
        r_stable = 1; r_busy_ready = 0; r_timeout = 0;
        r_data = '0; r_err = 1'b0; r_id = '0;
        for (int i = 0; i < 4; i++) r_addr[i] = '0;
        done = 0;
        while (!done) begin
            @(negedge clk_i);
            in_req_valid_i = 1'b1; in_req_addr_i = addr; in_req_id_i = id;
            mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; in_rsp_ready_i = 1'b0;
            #1;
            if (in_req_ready_o) done = 1;
            else begin
                r_accept_wait++;
                if (r_accept_wait > 50) begin r_timeout = 1; return; end
            end
        end
        cyc = 0; nreq = 0; nrsp = 0; done = 0; seen = 0;
        while (!done) begin
            cyc++;
            @(negedge clk_i);
            in_req_valid_i = chain;
            if (chain) begin in_req_addr_i = naddr; in_req_id_i = nid; end
            mem_req_ready_i = toggle ? (cyc % 2 == 0) : 1'b1;
            mem_rsp_valid_i = (q_due.size() > 0) && (q_due[0] <= cyc);
            mem_rsp_data_i  = mem_rsp_valid_i ? q_data[0] : 64'h0;
            mem_rsp_error_i = mem_rsp_valid_i ? q_err[0] : 1'b0;
            in_rsp_ready_i  = (r_vcnt >= hold);
            #1;
            if (in_req_ready_o) r_busy_ready = 1;
            if (mem_req_valid_o && mem_req_ready_i) begin
                if (nreq < 4) r_addr[nreq] = mem_req_addr_o;
                q_data.push_back(dbase + 64'(nreq));
                q_err.push_back(nreq == err_beat);
                q_due.push_back(cyc + lat);
                nreq++;
            end
            if (mem_rsp_valid_i && mem_rsp_ready_o) begin
                void'(q_data.pop_front()); void'(q_err.pop_front()); void'(q_due.pop_front());
                nrsp++;
            end
            if (in_rsp_valid_o) begin
                if (!seen) begin
                    seen = 1; r_valid_cyc = cyc;
                    r_data = in_rsp_data_o; r_err = in_rsp_error_o; r_id = in_rsp_id_o;
                end else if (in_rsp_data_o !== r_data || in_rsp_error_o !== r_err
                             || in_rsp_id_o !== r_id) begin
                    r_stable = 0;
                end
                r_vcnt++;
                if (in_rsp_ready_i) done = 1;
            end else if (seen) begin
                r_stable = 0;
            end
            r_nreq = nreq;
            if (abort_after > 0 && nrsp >= abort_after) return;
            if (cyc > 300) begin r_timeout = 1; return; end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i); #1;
            n_cmp++;
            if ({in_req_ready_o, in_rsp_valid_o, mem_req_valid_o, mem_rsp_ready_o} !== 4'b0) begin
                n_bad++;
                $display("FAIL reset_outputs got %b required 0000",
                         {in_req_ready_o, in_rsp_valid_o, mem_req_valid_o, mem_rsp_ready_o});
            end
        end
        n_cmp++;
        if (in_rsp_data_o !== 256'h0 || in_rsp_error_o !== 1'b0 || in_rsp_id_o !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_rsp_regs got %h/%b/%0d required 0/0/0",
                     in_rsp_data_o, in_rsp_error_o, in_rsp_id_o);
        end
        @(posedge clk_i); #1; rst_i = 1'b0;
        @(negedge clk_i); #1;
        n_cmp++;
        if ({in_req_ready_o, in_rsp_valid_o, mem_req_valid_o, mem_rsp_ready_o} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_first_cycle got %b required 0000",
                     {in_req_ready_o, in_rsp_valid_o, mem_req_valid_o, mem_rsp_ready_o});
        end
        @(negedge clk_i); #1;
        n_cmp++;
        if (in_req_ready_o !== 1'b1) begin
            n_bad++; $display("FAIL reset_second_cycle_ready got %b required 1", in_req_ready_o);
        end
    endtask

    task automatic test_basic();
        logic [47:0] ea [4];
        ea = '{48'h0000_1000_0000, 48'h0000_1000_0008, 48'h0000_1000_0010, 48'h0000_1000_0018};
        run_refill(48'h0000_1000_0013, 2'd2, 1, 0, 0, -1, 64'hA0, 0, 0, '0, '0);
        n_cmp++;
        if (r_timeout !== 1'b0) begin n_bad++; $display("FAIL basic_timeout got 1 required 0"); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (r_addr[i] !== ea[i]) begin
                n_bad++; $display("FAIL basic_addr%0d got %h required %h", i, r_addr[i], ea[i]);
            end
        end
        n_cmp++;
        if (r_data !== {64'hA3, 64'hA2, 64'hA1, 64'hA0}) begin
            n_bad++; $display("FAIL basic_data got %h required A3..A0", r_data);
        end
        n_cmp++;
        if (r_id !== 2'd2 || r_err !== 1'b0) begin
            n_bad++; $display("FAIL basic_id_err got %0d/%b required 2/0", r_id, r_err);
        end
        n_cmp++;
        if (r_valid_cyc !== 6) begin
            n_bad++; $display("FAIL basic_latency got %0d required 6", r_valid_cyc);
        end
        n_cmp++;
        if (r_nreq !== 4 || r_busy_ready !== 1'b0) begin
            n_bad++; $display("FAIL basic_nreq_busy got %0d/%b required 4/0", r_nreq, r_busy_ready);
        end
    endtask

    task automatic test_error();
        run_refill(48'h0000_2000_0040, 2'd1, 1, 0, 0, 2, 64'h1111_0000_0000_00B0, 0, 0, '0, '0);
        n_cmp++;
        if (r_nreq !== 4 || r_err !== 1'b1) begin
            n_bad++; $display("FAIL error_flag got nreq %0d err %b required 4/1", r_nreq, r_err);
        end
        n_cmp++;
        if (r_data !== {64'h1111_0000_0000_00B3, 64'h1111_0000_0000_00B2,
                        64'h1111_0000_0000_00B1, 64'h1111_0000_0000_00B0}) begin
            n_bad++; $display("FAIL error_data got %h", r_data);
        end
        run_refill(48'h0000_2000_0060, 2'd3, 1, 0, 0, -1, 64'hC0, 0, 0, '0, '0);
        n_cmp++;
        if (r_err !== 1'b0 || r_id !== 2'd3) begin
            n_bad++; $display("FAIL error_cleared got %b/%0d required 0/3", r_err, r_id);
        end
        n_cmp++;
        if (r_addr[0] !== 48'h0000_2000_0060 || r_data !== {64'hC3, 64'hC2, 64'hC1, 64'hC0}) begin
            n_bad++; $display("FAIL error_next_line got %h / %h", r_addr[0], r_data);
        end
    endtask

    task automatic test_backpressure();
        logic [47:0] ea [4];
        ea = '{48'h0000_3000_0020, 48'h0000_3000_0028, 48'h0000_3000_0030, 48'h0000_3000_0038};
        run_refill(48'h0000_3000_0020, 2'd0, 3, 1, 5, -1, 64'h2222_0000_0000_00D0, 0, 0, '0, '0);
        n_cmp++;
        if (r_timeout !== 1'b0 || r_nreq !== 4) begin
            n_bad++; $display("FAIL bp_progress got timeout %b nreq %0d", r_timeout, r_nreq);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (r_addr[i] !== ea[i]) begin
                n_bad++; $display("FAIL bp_addr%0d got %h required %h", i, r_addr[i], ea[i]);
            end
        end
        n_cmp++;
        if (r_data !== {64'h2222_0000_0000_00D3, 64'h2222_0000_0000_00D2,
                        64'h2222_0000_0000_00D1, 64'h2222_0000_0000_00D0}) begin
            n_bad++; $display("FAIL bp_data got %h", r_data);
        end
        n_cmp++;
        if (r_stable !== 1'b1 || r_vcnt !== 6) begin
            n_bad++; $display("FAIL bp_stable got stable %b valid_cycles %0d required 1/6",
                              r_stable, r_vcnt);
        end
        n_cmp++;
        if (r_busy_ready !== 1'b0) begin
            n_bad++; $display("FAIL bp_req_ready_busy got 1 required 0");
        end
        run_refill(48'h0000_3000_0100, 2'd1, 1, 0, 0, -1, 64'h50, 0, 0, '0, '0);
        n_cmp++;
        if (r_accept_wait !== 0) begin
            n_bad++; $display("FAIL bp_accept_after got wait %0d required 0", r_accept_wait);
        end
    endtask

    task automatic test_back_to_back();
        run_refill(48'h0000_4000_0000, 2'd0, 1, 0, 0, -1, 64'hE0, 0, 1, 48'h0000_4000_0100, 2'd1);
        n_cmp++;
        if (r_data !== {64'hE3, 64'hE2, 64'hE1, 64'hE0} || r_id !== 2'd0) begin
            n_bad++; $display("FAIL b2b_first got %h id %0d", r_data, r_id);
        end
        n_cmp++;
        if (r_busy_ready !== 1'b0) begin
            n_bad++; $display("FAIL b2b_busy_ready got 1 required 0");
        end
        run_refill(48'h0000_4000_0100, 2'd1, 1, 0, 0, -1, 64'hF0, 0, 0, '0, '0);
        n_cmp++;
        if (r_accept_wait !== 0) begin
            n_bad++; $display("FAIL b2b_accept got wait %0d required 0", r_accept_wait);
        end
        n_cmp++;
        if (r_data !== {64'hF3, 64'hF2, 64'hF1, 64'hF0} || r_id !== 2'd1
            || r_addr[3] !== 48'h0000_4000_0118) begin
            n_bad++; $display("FAIL b2b_second got %h id %0d a3 %h", r_data, r_id, r_addr[3]);
        end
    endtask

    task automatic test_reset_mid();
        bit saw_valid;
        run_refill(48'h0000_5000_0000, 2'd2, 1, 0, 0, -1, 64'h77, 2, 0, '0, '0);
        @(posedge clk_i); #1;
        rst_i = 1'b1; mem_rsp_valid_i = 1'b0; mem_req_ready_i = 1'b0; in_req_valid_i = 1'b0;
        in_rsp_ready_i = 1'b1;
        @(negedge clk_i); #1;
        n_cmp++;
        if ({in_req_ready_o, in_rsp_valid_o, mem_req_valid_o, mem_rsp_ready_o} !== 4'b0) begin
            n_bad++; $display("FAIL midrst_during got %b required 0000",
                {in_req_ready_o, in_rsp_valid_o, mem_req_valid_o, mem_rsp_ready_o});
        end
        @(posedge clk_i); #1; rst_i = 1'b0;
        @(negedge clk_i); #1;
        n_cmp++;
        if ({in_req_ready_o, in_rsp_valid_o, mem_req_valid_o, mem_rsp_ready_o} !== 4'b0) begin
            n_bad++; $display("FAIL midrst_after got %b required 0000",
                {in_req_ready_o, in_rsp_valid_o, mem_req_valid_o, mem_rsp_ready_o});
        end
        saw_valid = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i); #1;
            if (in_rsp_valid_o || mem_req_valid_o) saw_valid = 1;
        end
        n_cmp++;
        if (saw_valid !== 1'b0 || in_req_ready_o !== 1'b1) begin
            n_bad++; $display("FAIL midrst_idle got valid %b ready %b required 0/1",
                              saw_valid, in_req_ready_o);
        end
        run_refill(48'h0000_6000_0008, 2'd1, 1, 0, 0, -1, 64'h3333_0000_0000_0010, 0, 0, '0, '0);
        n_cmp++;
        if (r_addr[0] !== 48'h0000_6000_0000 || r_id !== 2'd1 || r_err !== 1'b0) begin
            n_bad++; $display("FAIL midrst_new got a0 %h id %0d err %b", r_addr[0], r_id, r_err);
        end
        n_cmp++;
        if (r_data !== {64'h3333_0000_0000_0013, 64'h3333_0000_0000_0012,
                        64'h3333_0000_0000_0011, 64'h3333_0000_0000_0010}) begin
            n_bad++; $display("FAIL midrst_data got %h", r_data);
        end
    endtask

    task automatic test_wrap();
        logic [47:0] ea [4];
        ea = '{48'hFFFF_FFFF_FFE0, 48'hFFFF_FFFF_FFE8, 48'hFFFF_FFFF_FFF0, 48'hFFFF_FFFF_FFF8};
        run_refill(48'hFFFF_FFFF_FFE0, 2'd3, 1, 0, 0, -1, 64'h44, 0, 0, '0, '0);
        n_cmp++;
        if (r_nreq !== 4 || r_timeout !== 1'b0) begin
            n_bad++; $display("FAIL wrap_nreq got %0d timeout %b", r_nreq, r_timeout);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (r_addr[i] !== ea[i]) begin
                n_bad++; $display("FAIL wrap_addr%0d got %h required %h", i, r_addr[i], ea[i]);
            end
        end
        n_cmp++;
        if (r_data !== {64'h47, 64'h46, 64'h45, 64'h44} || r_id !== 2'd3) begin
            n_bad++; $display("FAIL wrap_data got %h id %0d", r_data, r_id);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_error();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired before the summary");
        $fatal(1, "watchdog");
    end

endmodule
